// File: rtl/cory_rgb_dec2_ctrl_if.sv
// Pixel stream bundle between upstream source, the vertical decimation control and the horizontal decimator.
// The DUT side is the slave modport; the driver/monitor side is the master modport.
interface cory_rgb_dec2_ctrl_if;
    logic        i_a_v;
    logic [23:0] i_a_d;
    logic        i_a_sof;
    logic        o_a_r;
    logic        o_z_v;
    logic [23:0] o_z_d;
    logic        o_z_first;
    logic        i_z_r;

    modport master (
        output i_a_v, i_a_d, i_a_sof, i_z_r,
        input  o_a_r, o_z_v, o_z_d, o_z_first
    );

    modport slave (
        input  i_a_v, i_a_d, i_a_sof, i_z_r,
        output o_a_r, o_z_v, o_z_d, o_z_first
    );
endinterface

// File: rtl/cory_rgb_dec2_ctrl.sv
// Vertical decimate-by-2 ahead of the rgb horizontal decimator: even lines pass, odd lines are dropped.
// Zero latency (combinational pass-through); PASS follows downstream ready, IDLE/DROP always accept.
// Optional sticky framing-error flag built only with CORY_RGB_DEC2_CTRL_ERR_EN defined.
module cory_rgb_dec2_ctrl #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_width,
    output logic         o_err,
    cory_rgb_dec2_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] col_q, col_d;
    logic         a_r, z_v, z_first;
    logic         line_end, sof_beat;
`ifdef CORY_RGB_DEC2_CTRL_ERR_EN
    logic         err_q, err_d;
`endif

    assign line_end = (col_q == (i_width - W'(1)));
    assign sof_beat = bus.i_a_v && bus.i_a_sof;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        a_r     = 1'b1;
        z_v     = 1'b0;
        z_first = 1'b0;
`ifdef CORY_RGB_DEC2_CTRL_ERR_EN
        err_d   = err_q;
`endif
        if (i_width == '0) begin
            state_d = IDLE;
            col_d   = '0;
        end else if (sof_beat) begin
            // SOF restarts the frame from any state and is itself the first forwarded pixel
            a_r     = bus.i_z_r;
            z_v     = 1'b1;
            z_first = 1'b1;
            if (bus.i_z_r) begin
`ifdef CORY_RGB_DEC2_CTRL_ERR_EN
                if (state_q != IDLE && col_q != '0) err_d = 1'b1;
`endif
                if (i_width == W'(1)) begin
                    state_d = DROP;
                    col_d   = '0;
                end else begin
                    state_d = PASS;
                    col_d   = W'(1);
                end
            end
        end else begin
            case (state_q)
                PASS: begin
                    a_r     = bus.i_z_r;
                    z_v     = bus.i_a_v;
                    z_first = bus.i_a_v && (col_q == '0);
                    if (bus.i_a_v && bus.i_z_r) begin
                        col_d   = line_end ? '0 : col_q + W'(1);
                        state_d = line_end ? DROP : PASS;
                    end
                end
                DROP: begin
                    if (bus.i_a_v) begin
                        col_d   = line_end ? '0 : col_q + W'(1);
                        state_d = line_end ? PASS : DROP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        // Hold the stream quiet while reset is asserted, whatever the inputs do
        if (!reset_n) begin
            a_r     = 1'b1;
            z_v     = 1'b0;
            z_first = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

`ifdef CORY_RGB_DEC2_CTRL_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign bus.o_a_r     = a_r;
    assign bus.o_z_v     = z_v;
    assign bus.o_z_first = z_first;
    assign bus.o_z_d     = bus.i_a_d;

endmodule

// File: tb/tb_cory_rgb_dec2_ctrl.sv
// Directed bench for the vertical decimate-by-2 control; expected values are hand-derived per scenario.
module tb_cory_rgb_dec2_ctrl;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] i_width = '0;
    logic         o_err;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         exp_err;

    cory_rgb_dec2_ctrl_if bus ();

    cory_rgb_dec2_ctrl #(.W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_width (i_width),
        .o_err   (o_err),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus at the falling edge and let outputs settle.
    task automatic drive(input logic v, input logic [23:0] d, input logic sof, input logic zr);
        @(negedge clk);
        bus.i_a_v   = v;
        bus.i_a_d   = d;
        bus.i_a_sof = sof;
        bus.i_z_r   = zr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_a_v = 1'b0; bus.i_a_sof = 1'b0; bus.i_z_r = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_a_v = 1'b1; bus.i_a_sof = 1'b1; bus.i_z_r = 1'b1; bus.i_a_d = 24'h123456;
        i_width = 12'd4;
        reset_n = 1'b0;
        #3;
        n_checks++; if (bus.o_a_r !== 1'b1) begin n_fail++; $display("FAIL reset_a_r got %b expected 1", bus.o_a_r); end
        n_checks++; if (bus.o_z_v !== 1'b0) begin n_fail++; $display("FAIL reset_z_v got %b expected 0", bus.o_z_v); end
        n_checks++; if (bus.o_z_first !== 1'b0) begin n_fail++; $display("FAIL reset_z_first got %b expected 0", bus.o_z_first); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", o_err); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_nominal();
        logic fwd, first;
        logic [23:0] d;
        i_width = 12'd4;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            d = 24'h100000 + 24'(k);
            drive(1'b1, d, (k == 0), 1'b1);
            fwd   = ((k / 4) % 2) == 0;
            first = fwd && ((k % 4) == 0);
            n_checks++; if (bus.o_z_v !== fwd) begin n_fail++; $display("FAIL nominal_z_v beat %0d got %b expected %b", k, bus.o_z_v, fwd); end
            n_checks++; if (bus.o_z_first !== first) begin n_fail++; $display("FAIL nominal_first beat %0d got %b expected %b", k, bus.o_z_first, first); end
            n_checks++; if (bus.o_a_r !== 1'b1) begin n_fail++; $display("FAIL nominal_a_r beat %0d got %b expected 1", k, bus.o_a_r); end
            n_checks++; if (bus.o_z_d !== d) begin n_fail++; $display("FAIL nominal_z_d beat %0d got %h expected %h", k, bus.o_z_d, d); end
        end
    endtask

    task automatic test_backpressure();
        i_width = 12'd4;
        do_reset();
        drive(1'b1, 24'hA00000, 1'b1, 1'b1);
        drive(1'b1, 24'hA00001, 1'b0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 24'hA00002, 1'b0, 1'b0);
            n_checks++; if (bus.o_a_r !== 1'b0) begin n_fail++; $display("FAIL bp_stall_a_r cycle %0d got %b expected 0", s, bus.o_a_r); end
            n_checks++; if (bus.o_z_v !== 1'b1) begin n_fail++; $display("FAIL bp_stall_z_v cycle %0d got %b expected 1", s, bus.o_z_v); end
        end
        drive(1'b1, 24'hA00002, 1'b0, 1'b1);
        n_checks++; if (bus.o_a_r !== 1'b1) begin n_fail++; $display("FAIL bp_release_a_r got %b expected 1", bus.o_a_r); end
        n_checks++; if (bus.o_z_first !== 1'b0) begin n_fail++; $display("FAIL bp_release_first got %b expected 0", bus.o_z_first); end
        drive(1'b1, 24'hA00003, 1'b0, 1'b1);
        n_checks++; if (bus.o_z_v !== 1'b1) begin n_fail++; $display("FAIL bp_col3_z_v got %b expected 1", bus.o_z_v); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 24'hB00000 + 24'(k), 1'b0, 1'b0);
            n_checks++; if (bus.o_a_r !== 1'b1) begin n_fail++; $display("FAIL bp_drop_a_r beat %0d got %b expected 1", k, bus.o_a_r); end
            n_checks++; if (bus.o_z_v !== 1'b0) begin n_fail++; $display("FAIL bp_drop_z_v beat %0d got %b expected 0", k, bus.o_z_v); end
        end
        drive(1'b1, 24'hC00000, 1'b0, 1'b1);
        n_checks++; if (bus.o_z_v !== 1'b1) begin n_fail++; $display("FAIL bp_line2_z_v got %b expected 1", bus.o_z_v); end
        n_checks++; if (bus.o_z_first !== 1'b1) begin n_fail++; $display("FAIL bp_line2_first got %b expected 1", bus.o_z_first); end
    endtask

    task automatic test_presof_zero();
        i_width = 12'd4;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 24'h200000 + 24'(k), 1'b0, 1'b0);
            n_checks++; if (bus.o_a_r !== 1'b1) begin n_fail++; $display("FAIL presof_a_r beat %0d got %b expected 1", k, bus.o_a_r); end
            n_checks++; if (bus.o_z_v !== 1'b0) begin n_fail++; $display("FAIL presof_z_v beat %0d got %b expected 0", k, bus.o_z_v); end
        end
        @(negedge clk);
        i_width = 12'd0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 24'h210000 + 24'(k), (k == 0), 1'b1);
            n_checks++; if (bus.o_z_v !== 1'b0) begin n_fail++; $display("FAIL zero_w_z_v beat %0d got %b expected 0", k, bus.o_z_v); end
            n_checks++; if (bus.o_a_r !== 1'b1) begin n_fail++; $display("FAIL zero_w_a_r beat %0d got %b expected 1", k, bus.o_a_r); end
        end
        drive(1'b0, 24'h0, 1'b0, 1'b1);
        i_width = 12'd4;
        drive(1'b1, 24'h220000, 1'b0, 1'b1);
        n_checks++; if (bus.o_z_v !== 1'b0) begin n_fail++; $display("FAIL zero_w_idle_z_v got %b expected 0", bus.o_z_v); end
    endtask

    task automatic test_short_line();
        i_width = 12'd6;
        do_reset();
        drive(1'b1, 24'h300000, 1'b1, 1'b1);
        drive(1'b1, 24'h300001, 1'b0, 1'b1);
        drive(1'b1, 24'h300002, 1'b0, 1'b1);
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL short_err_before got %b expected 0", o_err); end
        drive(1'b1, 24'h310000, 1'b1, 1'b1);
        n_checks++; if (bus.o_z_v !== 1'b1) begin n_fail++; $display("FAIL short_sof_z_v got %b expected 1", bus.o_z_v); end
        n_checks++; if (bus.o_z_first !== 1'b1) begin n_fail++; $display("FAIL short_sof_first got %b expected 1", bus.o_z_first); end
        for (int k = 1; k < 6; k++) begin
            drive(1'b1, 24'h310000 + 24'(k), 1'b0, 1'b1);
            n_checks++; if (bus.o_z_v !== 1'b1) begin n_fail++; $display("FAIL short_line_z_v col %0d got %b expected 1", k, bus.o_z_v); end
            n_checks++; if (bus.o_z_first !== 1'b0) begin n_fail++; $display("FAIL short_line_first col %0d got %b expected 0", k, bus.o_z_first); end
        end
        n_checks++; if (o_err !== exp_err) begin n_fail++; $display("FAIL short_err_after got %b expected %b", o_err, exp_err); end
        drive(1'b1, 24'h320000, 1'b0, 1'b1);
        n_checks++; if (bus.o_z_v !== 1'b0) begin n_fail++; $display("FAIL short_line1_drop got %b expected 0", bus.o_z_v); end
    endtask

    task automatic test_reset_midline();
        i_width = 12'd4;
        drive(1'b1, 24'h400000, 1'b1, 1'b1);
        drive(1'b1, 24'h400001, 1'b0, 1'b1);
        drive(1'b1, 24'h400002, 1'b0, 1'b1);
        n_checks++; if (bus.o_z_v !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_z_v got %b expected 1", bus.o_z_v); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.o_a_r !== 1'b1) begin n_fail++; $display("FAIL rst_mid_a_r got %b expected 1", bus.o_a_r); end
        n_checks++; if (bus.o_z_v !== 1'b0) begin n_fail++; $display("FAIL rst_mid_z_v got %b expected 0", bus.o_z_v); end
        n_checks++; if (bus.o_z_first !== 1'b0) begin n_fail++; $display("FAIL rst_mid_first got %b expected 0", bus.o_z_first); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got %b expected 0", o_err); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 24'h410000 + 24'(k), 1'b0, 1'b1);
            n_checks++; if (bus.o_z_v !== 1'b0) begin n_fail++; $display("FAIL rst_post_z_v beat %0d got %b expected 0", k, bus.o_z_v); end
        end
        drive(1'b1, 24'h420000, 1'b1, 1'b1);
        n_checks++; if (bus.o_z_v !== 1'b1) begin n_fail++; $display("FAIL rst_new_sof_z_v got %b expected 1", bus.o_z_v); end
        n_checks++; if (bus.o_z_first !== 1'b1) begin n_fail++; $display("FAIL rst_new_sof_first got %b expected 1", bus.o_z_first); end
    endtask

    task automatic test_width1();
        logic fwd;
        i_width = 12'd1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 24'h500000 + 24'(k), (k == 0), 1'b1);
            fwd = (k % 2) == 0;
            n_checks++; if (bus.o_z_v !== fwd) begin n_fail++; $display("FAIL w1_z_v beat %0d got %b expected %b", k, bus.o_z_v, fwd); end
            n_checks++; if (bus.o_z_first !== fwd) begin n_fail++; $display("FAIL w1_first beat %0d got %b expected %b", k, bus.o_z_first, fwd); end
        end
    endtask

    initial begin
`ifdef CORY_RGB_DEC2_CTRL_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus.i_a_v = 1'b0; bus.i_a_d = '0; bus.i_a_sof = 1'b0; bus.i_z_r = 1'b1;
        test_reset();
        test_nominal();
        test_backpressure();
        test_presof_zero();
        test_short_line();
        test_reset_midline();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cory_rgb_dec2_ctrl.md
CORY_RGB_DEC2_CTRL -- requirements
Module: cory_rgb_dec2_ctrl

Interface
REQ-001 Parameter: W, 12, bit width of the column counter and of i_width.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: i_a_v  input  1  upstream pixel valid.
REQ-005 Port: i_a_d  input  24  upstream pixel {r,g,b}, 8 bits each.
REQ-006 Port: i_a_sof  input  1  start of frame; qualified by i_a_v; marks the first pixel of a frame.
REQ-007 Port: o_a_r  output  1  upstream ready.
REQ-008 Port: o_z_v  output  1  downstream valid, to the rgb horizontal decimator.
REQ-009 Port: o_z_d  output  24  downstream pixel.
REQ-010 Port: o_z_first  output  1  first pixel of a line; drives the decimator's first input.
REQ-011 Port: i_z_r  input  1  downstream ready.
REQ-012 Port: i_width  input  W  pixels per line; static while the block is not IDLE.
REQ-013 Port: o_err  output  1  sticky framing-error flag.

Function
REQ-014 Purpose: vertical decimation by 2 ahead of the horizontal rgb decimator; even lines pass, odd lines are consumed and discarded; line-start marking for the decimator.
REQ-015 Transfer: an upstream beat is accepted when i_a_v and o_a_r are both 1 on a rising clk edge.
REQ-016 State machine: three states, IDLE, PASS and DROP.
REQ-017 IDLE: o_a_r = 1; o_z_v = 0; accepted beats without i_a_sof are discarded.
REQ-018 PASS: o_z_v = i_a_v; o_a_r = i_z_r; o_z_d = i_a_d (combinational, zero latency).
REQ-019 DROP: o_a_r = 1; o_z_v = 0; each accepted beat is discarded at one beat per cycle.
REQ-020 o_z_d: equals i_a_d in every state; it is only meaningful when o_z_v = 1.
REQ-021 o_z_first = 1 when in PASS, i_a_v = 1 and col == 0; otherwise 0.
REQ-022 Start of frame: when a beat with i_a_sof = 1 is accepted (any state, i_width != 0), that beat is line 0, col 0, and is forwarded downstream.
REQ-023 SOF routing: the SOF beat is forwarded combinationally with o_z_first = 1 (o_a_r = i_z_r for that beat); the state then becomes PASS with col = 1.
REQ-024 SOF with width 1: if i_width == 1, the SOF beat ends the line and the state becomes DROP with col = 0.
REQ-025 Column counter: col (W bits) increments on each accepted beat in PASS or DROP.
REQ-026 Line end: when col == i_width-1, col wraps to 0 and the state toggles PASS->DROP or DROP->PASS.
REQ-027 i_width == 0: the state stays or returns to IDLE; all beats are accepted and discarded; o_z_v = 0.
REQ-028 SOF mid-line (col != 0 in PASS or DROP): the frame restarts per REQ-022.
REQ-029 Backpressure: in PASS, a stalled beat (i_a_v = 1, i_z_r = 0) changes no state.

Reset
REQ-030 Reset values: on reset_n = 0, asynchronously, state = IDLE, col = 0 and o_err = 0.
REQ-031 Outputs during reset: o_a_r = 1, o_z_v = 0 and o_z_first = 0.
REQ-032 Reset mid-line: reset_n asserted mid-line abandons the line; no further downstream beats occur until the next SOF.

Configuration
REQ-033 Macro CORY_RGB_DEC2_CTRL_ERR_EN defined: o_err sets on an accepted SOF while col != 0 in PASS or DROP; it stays 1 until reset.
REQ-034 Macro CORY_RGB_DEC2_CTRL_ERR_EN undefined: o_err is constant 0 and no error logic is built; all other behaviour is identical.

Verification
REQ-035 Nominal frame: i_width = 4, SOF, then 16 beats with i_z_r = 1 -> beats 0-3 and 8-11 forwarded, o_z_first on beats 0 and 8, beats 4-7 and 12-15 dropped.
REQ-036 Backpressure: i_width = 4, i_z_r low for 3 cycles at col 2 of line 0 -> o_a_r = 0 and col held at 2; beat forwarded once i_z_r = 1; line 1 drop is unaffected by i_z_r.
REQ-037 Pre-SOF and zero width: 5 beats before SOF -> all accepted, o_z_v = 0; i_width = 0 with SOF -> nothing forwarded, state IDLE.
REQ-038 Short line: i_width = 6, SOF at col 3 of line 0 -> new line 0 forwarded with o_z_first = 1; o_err = 1 with CORY_RGB_DEC2_CTRL_ERR_EN, 0 without it.
REQ-039 Reset: reset_n pulsed low at col 2 of a PASS line -> outputs take reset values immediately; following beats are discarded until SOF; o_err clears.
REQ-040 Width 1: i_width = 1 with 4 beats -> beats 0 and 2 forwarded, each with o_z_first = 1.
